dift_tag_override_ctrl: RTL

Parametrised DIFT tag-override stage between a core-side TCDM master and the interconnect. On each granted read it records the override decision from up to NR_RULES programmable address ranges. When that read's response returns, it applies the decision to the tag bits of r_rdata. Decisions are held in an in-order outstanding queue, so the override is bound to the request address, not to whatever address is on the bus when the response arrives. Adds zero latency; used for hardware tag initialisation and taint forcing per memory region.

---
 rtl/dift_tag_override_ctrl_if.sv | 28 ++
 rtl/dift_tag_override_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dift_tag_override_ctrl_if.sv
// TCDM request/response bundle carrying DATA_W payload plus TAG_W tag bits.
//   req/add/wen/be/wdata : request, driven by the master (wen=1 means read)
//   gnt                  : request grant, driven by the slave
//   r_valid/r_opc/r_rdata: response, driven by the slave
interface dift_tag_override_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
);
  logic                    req;
  logic [31:0]             add;
  logic                    wen;
  logic [DATA_W/8-1:0]     be;
  logic [DATA_W+TAG_W-1:0] wdata;
  logic                    gnt;
  logic                    r_valid;
  logic                    r_opc;
  logic [DATA_W+TAG_W-1:0] r_rdata;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_opc, r_rdata
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_opc, r_rdata
  );
endinterface

// File: rtl/dift_tag_override_ctrl.sv
// DIFT tag-override stage between a core-side TCDM master and the interconnect.
// Each granted read records an override decision from the address rules; the
// decision is applied to the tag bits of the matching in-order response.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   s_bus (slave)           : upstream TCDM port from the core
//   m_bus (master)          : downstream TCDM port to the interconnect
//   rule_en/start/end/mode/tag_i : NR_RULES address ranges [start, end)
//   cnt_clr_i               : synchronous clear of override_cnt_o
//   override_cnt_o          : saturating count of modified responses
//   err_o                   : sticky flag, response seen with empty queue
module dift_tag_override_ctrl #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned TAG_W           = 4,
  parameter int unsigned NR_RULES        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  dift_tag_override_ctrl_if.slave    s_bus,
  dift_tag_override_ctrl_if.master   m_bus,
  input  logic [NR_RULES-1:0]        rule_en_i,
  input  logic [31:0]                rule_start_i [NR_RULES],
  input  logic [31:0]                rule_end_i   [NR_RULES],
  input  logic [1:0]                 rule_mode_i  [NR_RULES],
  input  logic [TAG_W-1:0]           rule_tag_i   [NR_RULES],
  input  logic                       cnt_clr_i,
  output logic [31:0]                override_cnt_o,
  output logic                       err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned DEPTH = 1 << PTR_W;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_SET   = 2'd1,
    MODE_CLEAR = 2'd2,
    MODE_FORCE = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e            mode;
    logic [TAG_W-1:0] tag;
  } decision_t;

  decision_t        fifo_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      ovr_cnt_q, ovr_cnt_d;
  logic             err_q, err_d;

  decision_t        match_dec;
  decision_t        resp_dec;
  logic             full, empty, gnt, push, pop, underflow;
  logic [TAG_W-1:0] resp_tag;

  // Rule match: iterate from the top so the lowest matching index is the last writer.
  always_comb begin
    match_dec.mode = MODE_PASS;
    match_dec.tag  = '0;
    for (int i = int'(NR_RULES) - 1; i >= 0; i--) begin
      if (rule_en_i[i] && (rule_start_i[i] <= s_bus.add) && (s_bus.add < rule_end_i[i])) begin
        match_dec.mode = mode_e'(rule_mode_i[i]);
        match_dec.tag  = rule_tag_i[i];
      end
    end
    if (!s_bus.wen) begin
      match_dec.mode = MODE_PASS;
      match_dec.tag  = '0;
    end
  end

  // Full is taken from registered state only, so a same-cycle pop never frees a slot.
  assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty     = (count_q == '0);
  assign gnt       = m_bus.gnt & ~full;
  assign push      = s_bus.req & gnt;
  assign pop       = m_bus.r_valid & ~empty;
  assign underflow = m_bus.r_valid & empty;

  // Request path passthrough.
  assign m_bus.req   = s_bus.req & ~full;
  assign m_bus.add   = s_bus.add;
  assign m_bus.wen   = s_bus.wen;
  assign m_bus.be    = s_bus.be;
  assign m_bus.wdata = s_bus.wdata;
  assign s_bus.gnt   = gnt;

  // Response path: tag rewrite from the queue head; underflow falls back to PASS.
  always_comb begin
    resp_dec.mode = MODE_PASS;
    resp_dec.tag  = '0;
    if (pop) begin
      resp_dec = fifo_q[head_q];
    end
    resp_tag = m_bus.r_rdata[DATA_W+TAG_W-1:DATA_W];
    unique case (resp_dec.mode)
      MODE_SET:   resp_tag = '1;
      MODE_CLEAR: resp_tag = '0;
      MODE_FORCE: resp_tag = resp_dec.tag;
      default:    resp_tag = m_bus.r_rdata[DATA_W+TAG_W-1:DATA_W];
    endcase
  end

  assign s_bus.r_valid = m_bus.r_valid;
  assign s_bus.r_opc   = m_bus.r_opc;
  assign s_bus.r_rdata = {resp_tag, m_bus.r_rdata[DATA_W-1:0]};

  // Next-state for pointers, occupancy, counter and error flag.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ovr_cnt_d = ovr_cnt_q;
    err_d     = err_q | underflow;

    if (push) begin
      tail_d = (tail_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = (head_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : head_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (cnt_clr_i) begin
      ovr_cnt_d = '0;
    end else if (pop && (resp_dec.mode != MODE_PASS) && (ovr_cnt_q != 32'hFFFF_FFFF)) begin
      ovr_cnt_d = ovr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ovr_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ovr_cnt_q <= ovr_cnt_d;
      err_q     <= err_d;
    end
  end

  // Decision storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[tail_q] <= match_dec;
    end
  end

  assign override_cnt_o = ovr_cnt_q;
  assign err_o          = err_q;

endmodule
